// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode, receiver state encoding, and the
// elaboration-time NCO increment calculation also used by the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } uart_rx_state_e;

  // round(2^width * oversample * baud / clk_freq); the real-to-integer cast rounds to nearest
  function automatic longint nco_incr(real clk_freq, real baud, int oversample, int width);
    real r;
    r = (2.0 ** width) * real'(oversample) * baud / clk_freq;
    return longint'(r);
  endfunction

  function automatic logic maj3(logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; extra pointer MSB distinguishes full from empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot the push needs
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_multi.sv
// Oversampling UART receiver with majority-vote sampling and a FWFT word FIFO.
// Optional feature: define UART_RX_BREAK_DET_EN to add the break_det output.
module uart_rx_multi
  import uart_pkg::*;
#(
  parameter real     CLK_FREQ   = 100.0e6,
  parameter int      BAUD_RATE  = 115200,
  parameter int      NCO_WIDTH  = 16,
  parameter int      OVERSAMPLE = 16,
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                 break_det,
`endif
  output logic                 busy
);

  localparam longint NCO_INCR = nco_incr(CLK_FREQ, real'(BAUD_RATE), OVERSAMPLE, NCO_WIDTH);
  localparam logic [NCO_WIDTH-1:0] INCR_V = NCO_WIDTH'(NCO_INCR);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = RX_IDLE;
  localparam logic [2:0] S_START     = RX_START;
  localparam logic [2:0] S_DATA      = RX_DATA;
  localparam logic [2:0] S_PARITY    = RX_PARITY;
  localparam logic [2:0] S_STOP      = RX_STOP;
  localparam logic [2:0] S_WAIT_HIGH = RX_WAIT_HIGH;

  if (NCO_INCR < 1 || NCO_INCR >= (longint'(1) << NCO_WIDTH)) begin : g_bad_incr
    $error("uart_rx_multi: NCO increment out of range for this clock/baud");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
    $error("uart_rx_multi: OVERSAMPLE must be 8 or 16");
  end

  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;
  logic                 rx_s;
  logic [NCO_WIDTH-1:0] nco_q;
  logic [NCO_WIDTH:0]   nco_sum;
  logic                 tick;
  logic [2:0]           hist_q;
  logic                 vote;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] word_q;
  logic                 par_q;
  logic                 stop1_q;
  logic                 at_sample;
  logic                 first_stop, brk_cond, fe_cond, pe_cond;

  logic frame_q, frame_d, parity_q, parity_d, overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DET_EN
  logic break_q, break_d;
`endif

  logic                 push, pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;

  assign rx_s    = sync2_q;
  assign nco_sum = {1'b0, nco_q} + {1'b0, INCR_V};
  assign tick    = nco_sum[NCO_WIDTH];
  assign vote    = maj3(hist_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      nco_q   <= '0;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      nco_q   <= nco_sum[NCO_WIDTH-1:0];
      if (tick) hist_q <= {hist_q[1:0], rx_s};
    end
  end

  assign at_sample  = (cnt_q == LAST_TICK);
  assign first_stop = (bit_q == 4'd0) ? vote : stop1_q;
  assign fe_cond    = !vote || !first_stop;
  // Break: every bit from data through the first stop sample read as 0
  assign brk_cond   = (word_q == '0) && ((PARITY == PAR_NONE) || !par_q) && !first_stop;
  assign pe_cond    = (PARITY != PAR_NONE) && ((^word_q ^ par_q) != (PARITY == PAR_ODD));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = 1'b0;
    parity_d  = 1'b0;
    overrun_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    break_d   = 1'b0;
`endif
    push      = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (hist_q[0] && !rx_s) begin
            state_d = S_START;
            cnt_d   = CNT_ONE;
          end
        end
        S_START: begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else if (cnt_q == HALF_M1) begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (at_sample) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == LAST_DATA) begin
              bit_d   = 4'd0;
              state_d = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
            end
          end
        end
        S_PARITY: begin
          cnt_d = cnt_q + 1'b1;
          if (at_sample) state_d = S_STOP;
        end
        S_STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (at_sample) begin
            if (bit_q != LAST_STOP) begin
              bit_d = bit_q + 1'b1;
            end else begin
              state_d = (vote && !brk_cond) ? S_IDLE : S_WAIT_HIGH;
`ifdef UART_RX_BREAK_DET_EN
              if (brk_cond) break_d = 1'b1;
              else
`endif
              if (fe_cond) frame_d = 1'b1;
              else if (pe_cond) parity_d = 1'b1;
              else if (fifo_full && !pop) overrun_d = 1'b1;
              else push = 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      frame_q   <= 1'b0;
      parity_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      parity_q  <= parity_d;
      overrun_q <= overrun_d;
`ifdef UART_RX_BREAK_DET_EN
      break_q   <= break_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (tick && at_sample) begin
      if (state_q == S_DATA)   word_q <= {vote, word_q[DATA_BITS-1:1]};
      if (state_q == S_PARITY) par_q  <= vote;
      if (state_q == S_STOP && bit_q == 4'd0) stop1_q <= vote;
    end
  end

  assign pop = rvalid && rready;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (word_q),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign rvalid      = !fifo_empty;
  assign rdata       = rvalid ? fifo_head : '0;
  assign frame_err   = frame_q;
  assign parity_err  = parity_q;
  assign overrun_err = overrun_q;
`ifdef UART_RX_BREAK_DET_EN
  assign break_det   = break_q;
`endif
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_multi.sv
// Scoreboard bench: an 8N1/16x receiver (A) and a 7-bit odd-parity, 2-stop, 8x receiver (B).
module tb_uart_rx_multi;
  import uart_pkg::*;

  localparam int BIT   = 100;  // 1 Mbaud at 100 MHz
  localparam int E_FRM = 1;
  localparam int E_PAR = 2;
  localparam int E_OVR = 4;
  localparam int E_BRK = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rready_a = 1'b0;
  logic       rx_b = 1'b1, rready_b = 1'b0;
  logic [7:0] rdata_a;
  logic [6:0] rdata_b;
  logic       rvalid_a, fer_a, per_a, ovr_a, busy_a, brk_a;
  logic       rvalid_b, fer_b, per_b, ovr_b, busy_b, brk_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rv_cnt_a = 0;
  logic busy_seen_a = 1'b0;
  int   qd_a[$], qe_a[$], qd_b[$], qe_b[$];

  always #5 clk = ~clk;

  uart_rx_multi #(
    .CLK_FREQ(100.0e6), .BAUD_RATE(1_000_000), .NCO_WIDTH(16), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .uart_rx(rx_a), .rdata(rdata_a), .rvalid(rvalid_a),
    .rready(rready_a), .frame_err(fer_a), .parity_err(per_a), .overrun_err(ovr_a),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_a),
`endif
    .busy(busy_a)
  );

  uart_rx_multi #(
    .CLK_FREQ(100.0e6), .BAUD_RATE(1_000_000), .NCO_WIDTH(16), .OVERSAMPLE(8),
    .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .uart_rx(rx_b), .rdata(rdata_b), .rvalid(rvalid_b),
    .rready(rready_b), .frame_err(fer_b), .parity_err(per_b), .overrun_err(ovr_b),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(brk_b),
`endif
    .busy(busy_b)
  );

`ifndef UART_RX_BREAK_DET_EN
  assign brk_a = 1'b0;
  assign brk_b = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT) @(posedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input logic has_par, input logic par_bit,
                            input int nstop, input logic stop_low);
    set_line(sel, 1'b0);
    wait_bits(1);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, data[i]);
      wait_bits(1);
    end
    if (has_par) begin
      set_line(sel, par_bit);
      wait_bits(1);
    end
    for (int i = 0; i < nstop; i++) begin
      set_line(sel, !stop_low);
      wait_bits(1);
    end
  endtask

  // Monitor A: pops the scoreboard on every handshake and every error pulse
  always @(negedge clk) begin
    int ev;
    if (!rst) begin
      if (rvalid_a) rv_cnt_a++;
      if (busy_a) busy_seen_a = 1'b1;
      if (rvalid_a && rready_a) begin
        if (qd_a.size() == 0) check("a_unexpected_word", int'(rdata_a), -1);
        else                  check("a_word", int'(rdata_a), qd_a.pop_front());
      end
      ev = int'({brk_a, ovr_a, per_a, fer_a});
      if (ev != 0) begin
        if (qe_a.size() == 0) check("a_unexpected_err", ev, -1);
        else                  check("a_err", ev, qe_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    int ev;
    if (!rst) begin
      if (rvalid_b && rready_b) begin
        if (qd_b.size() == 0) check("b_unexpected_word", int'(rdata_b), -1);
        else                  check("b_word", int'(rdata_b), qd_b.pop_front());
      end
      ev = int'({brk_b, ovr_b, per_b, fer_b});
      if (ev != 0) begin
        if (qe_b.size() == 0) check("b_unexpected_err", ev, -1);
        else                  check("b_err", ev, qe_b.pop_front());
      end
    end
  end

  initial begin
    int rv0;
    repeat (3) @(negedge clk);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rdata_a", int'(rdata_a), 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_errs_a", int'({brk_a, ovr_a, per_a, fer_a}), 0);
    check("rst_rvalid_b", rvalid_b, 0);
    check("rst_busy_b", busy_b, 0);
    @(posedge clk);
    rst = 1'b0;
    wait_bits(2);

    // 8N1 good word 0xA5
    rready_a = 1'b1;
    rready_b = 1'b1;
    rv0 = rv_cnt_a;
    qd_a.push_back('hA5);
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0);
    wait_bits(3);
    check("a_rvalid_cycles", rv_cnt_a - rv0, 1);
    check("a_pending_good", qd_a.size() + qe_a.size(), 0);

    // 0x55 with stop low, then line held low
    qe_a.push_back(E_FRM);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1);
    wait_bits(5);
    check("a_busy_line_low", busy_a, 1);
    set_line(0, 1'b1);
    wait_bits(1);
    check("a_busy_released", busy_a, 0);
    check("a_pending_frame", qd_a.size() + qe_a.size(), 0);

    // Overrun: five words into a depth-4 FIFO with no reader
    rready_a = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) qd_a.push_back(b);
      else        qe_a.push_back(E_OVR);
      send_frame(0, 9'(b), 8, 1'b0, 1'b0, 1, 1'b0);
      wait_bits(2);
    end
    @(negedge clk);
    check("a_full_rvalid", rvalid_a, 1);
    check("a_full_head", int'(rdata_a), 1);
    check("a_pending_ovr", qe_a.size(), 0);
    rready_a = 1'b1;
    wait_bits(1);
    check("a_pending_drain", qd_a.size() + qe_a.size(), 0);

    // Short low glitch on an idle line
    busy_seen_a = 1'b0;
    rv0 = rv_cnt_a;
    set_line(0, 1'b0);
    repeat (40) @(posedge clk);
    set_line(0, 1'b1);
    wait_bits(2);
    check("a_glitch_busy_seen", busy_seen_a, 1);
    check("a_glitch_busy_idle", busy_a, 0);
    check("a_glitch_no_word", rv_cnt_a - rv0, 0);

    // Line held low for two frame times, then 0x5A
`ifdef UART_RX_BREAK_DET_EN
    qe_a.push_back(E_BRK);
`else
    qe_a.push_back(E_FRM);
`endif
    set_line(0, 1'b0);
    wait_bits(20);
    check("a_busy_break", busy_a, 1);
    set_line(0, 1'b1);
    wait_bits(2);
    check("a_break_idle", busy_a, 0);
    check("a_pending_break", qd_a.size() + qe_a.size(), 0);
    qd_a.push_back('h5A);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
    wait_bits(3);
    check("a_pending_5a", qd_a.size() + qe_a.size(), 0);

    // 7O2: 0x3C has four ones, so the odd parity bit is 1
    qd_b.push_back('h3C);
    send_frame(1, 9'h03C, 7, 1'b1, 1'b1, 2, 1'b0);
    wait_bits(2);
    qe_b.push_back(E_PAR);
    send_frame(1, 9'h03C, 7, 1'b1, 1'b0, 2, 1'b0);
    wait_bits(3);
    check("b_pending", qd_b.size() + qe_b.size(), 0);
    check("b_busy_end", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_multi.md
# uart_rx_multi

Parametrised UART receiver with runtime-independent frame format: 5–9 data bits, none/even/odd parity, 1–2 stop bits and 8x or 16x oversampling. It samples each bit with a 3-sample majority vote and reports framing, parity and overrun errors separately. Received words go into a first-word-fall-through FIFO with a ready/valid read port. It sits between the synchronised serial input pin and the byte-consuming fabric.

## Interface
- CLK_FREQ, 100E6: system clock in Hz
- BAUD_RATE, 115200: line rate in bit/s
- NCO_WIDTH, 16: phase accumulator width
- OVERSAMPLE, 16: ticks per bit; legal values are 8 and 16
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first
- PARITY, PAR_NONE: parity mode, type uart_pkg::parity_e (PAR_NONE/PAR_EVEN/PAR_ODD)
- STOP_BITS, 1: stop bits per frame, 1..2
- FIFO_DEPTH, 4: receive FIFO depth, a power of two ≥2
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- uart_rx  in  1  serial line (asynchronous, idle high)
- rdata  out  DATA_BITS  FIFO head word
- rvalid  out  1  FIFO not empty
- rready  in  1  consumer accepts the head word
- frame_err  out  1  one-cycle pulse: a stop bit sampled low
- parity_err  out  1  one-cycle pulse: parity mismatch
- overrun_err  out  1  one-cycle pulse: word lost because the FIFO was full
- busy  out  1  a frame is in progress (any state other than IDLE)

## Operation
- **Input synchroniser:** 2-flop synchroniser (ASYNC_REG) on uart_rx; all logic uses the synchronised value.
- **Tick generator:** NCO_INCR = round(2^NCO_WIDTH · OVERSAMPLE · BAUD_RATE / CLK_FREQ). Elaboration fails unless 1 ≤ NCO_INCR < 2^NCO_WIDTH. The carry out of the accumulator is the one-cycle `tick`.
- **Sample history:** a 3-bit shift register of synchronised samples, shifted on each tick. `vote` is the majority of those 3 bits.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE → START when one high sample is followed by a low sample.
  - START counts consecutive low ticks. A high tick returns it to IDLE (glitch rejection). Reaching OVERSAMPLE/2 consecutive lows marks mid start bit; the tick counter clears and the FSM enters DATA.
  - DATA takes a sample point every OVERSAMPLE ticks and shifts `vote` into the word, LSB first. After DATA_BITS samples it goes to PARITY, or to STOP when PARITY is PAR_NONE.
  - PARITY captures the parity bit at one sample point.
  - STOP takes STOP_BITS sample points. Any low stop sample latches a frame error.
  - After the final stop sample: go to IDLE if the line is high, otherwise to WAIT_HIGH. WAIT_HIGH → IDLE on the first high sample.
- **Frame completion** happens at the final stop sample, with priority: frame error > parity error > overrun > good.
  - Good frame: the word is pushed into the FIFO.
  - Any error: the word is discarded and exactly one matching error pulse is issued.
- **Parity rules:** even parity means the XOR of data and parity bits is 0. Odd parity means that XOR is 1.
- **FIFO behaviour:**
  - rvalid = not empty; rdata = head word.
  - A pop happens on rvalid && rready.
  - A push into a full FIFO in the same cycle as a pop is accepted, not counted as overrun.
  - rready while empty has no effect.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- **Reset mid-frame:** the frame is aborted, the FIFO is emptied and the FSM returns to IDLE.

## Timing
- Reset values: rdata 0, rvalid 0, all error pulses 0, busy 0, NCO 0, FSM IDLE, sample history all-ones.
- Error pulses are registered. Each lasts exactly one clk cycle, in the cycle after the final stop sample tick.
- A good word is written on the same edge as that pulse slot. rvalid rises in the cycle after the write (FIFO latency 1).
- A pop on edge N updates rdata/rvalid at edge N.
- busy rises on the IDLE→START edge and falls on the exit from STOP or WAIT_HIGH.

## Configuration
- Macro `UART_RX_BREAK_DET_EN`.
  - **Defined:** adds output port `break_det` (1 bit, reset 0). When all data bits, the parity bit (if present) and the first stop sample are all 0, the block pulses break_det for one cycle instead of frame_err, pushes nothing, and enters WAIT_HIGH.
  - **Undefined:** the port is absent. The same condition gives frame_err followed by WAIT_HIGH.

## Structure
- Package `uart_pkg` holds:
  - `parity_e`
  - `uart_rx_state_e`
  - function `nco_incr(clk_freq, baud, oversample, width)`, shared with the transmitter.
- Sub-module `uart_rx_fifo`: synchronous FIFO with parameters WIDTH and DEPTH, the same clock/reset, push/full on the write side, pop/empty/head on the read side. The FSM, synchroniser and NCO stay in the top module.

## Test plan
- 8N1 at 115200 baud, send 0xA5 with rready=1 → rdata=0xA5 and rvalid pulses once; no error pulses.
- DATA_BITS=7, PAR_ODD, STOP_BITS=2: send 0x3C with correct parity → 0x3C received. Resend with parity inverted → parity_err=1 once, no push.
- 8N1: send 0x55 with the stop bit forced low → frame_err=1 once and no push. Hold the line low, then release → busy deasserts only after the line returns high.
- FIFO_DEPTH=4, rready=0: send 0x01..0x05 → the FIFO holds 0x01..0x04, overrun_err pulses once on byte 5. Drain with rready=1 → 0x01, 0x02, 0x03, 0x04 in order.
- Low glitch of OVERSAMPLE/2−1 ticks on an idle line → no start: busy pulses and returns to IDLE without any push.
- With `UART_RX_BREAK_DET_EN`: hold the line low for 2 frame times → break_det=1 once, frame_err=0, no push. Then send 0x5A → received correctly.
